// File: rtl/bru_issue_queue.sv
// Branch/jump issue queue. Entries are kept age-ordered and collapse on pop.
// The oldest ready entry issues into a registered output stage with valid/ready backpressure.
module bru_issue_queue #(
   parameter int DP      = 4,
   parameter int RNDEPTH = 4,
   parameter int RNBIT   = 2,
   parameter int XLEN    = 64,
   parameter int OPW     = 8
) (
   input  logic                        CLK,
   input  logic                        RSTn,
   input  logic                        flush,
   input  logic                        dispat_valid,
   output logic                        dispat_ready,
   input  logic [OPW-1:0]              dispat_op,
   input  logic [XLEN-1:0]             dispat_pc,
   input  logic [XLEN-1:0]             dispat_imm,
   input  logic [5+RNBIT-1:0]          dispat_rd0,
   input  logic [5+RNBIT-1:0]          dispat_rs1,
   input  logic [5+RNBIT-1:0]          dispat_rs2,
   input  logic                        dispat_is_rvc,
   input  logic [32*RNDEPTH-1:0]       wb_buffer_qout,
   input  logic [XLEN*32*RNDEPTH-1:0]  regFileX_read,
   output logic                        execute_valid,
   input  logic                        execute_ready,
   output logic [OPW-1:0]              execute_op,
   output logic [XLEN-1:0]             execute_pc,
   output logic [XLEN-1:0]             execute_imm,
   output logic [5+RNBIT-1:0]          execute_rd0,
   output logic [XLEN-1:0]             execute_src1,
   output logic [XLEN-1:0]             execute_src2,
   output logic                        execute_is_rvc
);

   localparam int PW = 5 + RNBIT;
   localparam int IW = $clog2(DP);

   typedef struct packed {
      logic [OPW-1:0]  op;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [PW-1:0]   rd0;
      logic [PW-1:0]   rs1;
      logic [PW-1:0]   rs2;
      logic            rvc;
   } entry_t;

   logic [DP-1:0] q_valid, n_valid, rdy, s1_ok, s2_ok;
   entry_t        q_ent [DP];
   entry_t        n_ent [DP];
   entry_t        d_ent, sel_ent;
   logic [IW-1:0] sel;
   logic [IW:0]   cnt, push_idx;
   logic          any_ready, full, out_free, pop, push;
   logic [XLEN-1:0] src1, src2;

   assign d_ent = '{dispat_op, dispat_pc, dispat_imm, dispat_rd0, dispat_rs1, dispat_rs2, dispat_is_rvc};

   // A source in architectural x0 never waits on write-back
   always_comb begin
      s1_ok = '0;
      s2_ok = '0;
      rdy   = '0;
      for (int i = 0; i < DP; i++) begin
         s1_ok[i] = (q_ent[i].rs1[PW-1:RNBIT] == 5'd0) | wb_buffer_qout[q_ent[i].rs1];
         s2_ok[i] = (q_ent[i].rs2[PW-1:RNBIT] == 5'd0) | wb_buffer_qout[q_ent[i].rs2];
         if (q_ent[i].op[0])      rdy[i] = 1'b1;
         else if (q_ent[i].op[1]) rdy[i] = s1_ok[i];
         else                     rdy[i] = s1_ok[i] & s2_ok[i];
      end
   end

   always_comb begin
      sel = '0;
      for (int i = DP-1; i >= 0; i--)
         if (q_valid[i] & rdy[i]) sel = IW'(i);
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < DP; i++) cnt = cnt + (IW+1)'(q_valid[i]);
   end

   assign any_ready    = |(q_valid & rdy);
   assign full         = &q_valid;
   assign out_free     = ~execute_valid | execute_ready;
   assign pop          = out_free & any_ready & ~flush;
   assign dispat_ready = ~flush & (~full | pop);
   assign push         = dispat_valid & dispat_ready;
   assign push_idx     = cnt - (IW+1)'(pop);

   assign sel_ent = q_ent[sel];
   assign src1 = (sel_ent.rs1[PW-1:RNBIT] == 5'd0) ? '0 : regFileX_read[XLEN*int'(sel_ent.rs1) +: XLEN];
   assign src2 = (sel_ent.rs2[PW-1:RNBIT] == 5'd0) ? '0 : regFileX_read[XLEN*int'(sel_ent.rs2) +: XLEN];

   // Collapse above the popped slot first, then place the new entry after the survivors
   always_comb begin
      n_valid = q_valid;
      n_ent   = q_ent;
      if (pop) begin
         for (int i = 0; i < DP-1; i++) begin
            if (i >= int'(sel)) begin
               n_valid[i] = q_valid[i+1];
               n_ent[i]   = q_ent[i+1];
            end
         end
         n_valid[DP-1] = 1'b0;
      end
      if (push) begin
         for (int i = 0; i < DP; i++) begin
            if (i == int'(push_idx)) begin
               n_valid[i] = 1'b1;
               n_ent[i]   = d_ent;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         q_valid <= '0;
         for (int i = 0; i < DP; i++) q_ent[i] <= '0;
      end else if (flush) begin
         q_valid <= '0;
      end else begin
         q_valid <= n_valid;
         q_ent   <= n_ent;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         execute_valid  <= 1'b0;
         execute_op     <= '0;
         execute_pc     <= '0;
         execute_imm    <= '0;
         execute_rd0    <= '0;
         execute_src1   <= '0;
         execute_src2   <= '0;
         execute_is_rvc <= 1'b0;
      end else if (flush) begin
         execute_valid <= 1'b0;
      end else if (pop) begin
         execute_valid  <= 1'b1;
         execute_op     <= sel_ent.op;
         execute_pc     <= sel_ent.pc;
         execute_imm    <= sel_ent.imm;
         execute_rd0    <= sel_ent.rd0;
         execute_src1   <= src1;
         execute_src2   <= src2;
         execute_is_rvc <= sel_ent.rvc;
      end else if (out_free) begin
         execute_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bru_issue_queue.sv
// Directed bench for bru_issue_queue: issue order, RAW wait, collapse, stall, flush, x0 sources, reset.
module tb_bru_issue_queue;

   localparam int DP = 4, RNDEPTH = 4, RNBIT = 2, XLEN = 64, OPW = 8, PW = 7;

   logic                       CLK = 1'b0;
   logic                       RSTn;
   logic                       flush;
   logic                       dispat_valid;
   logic                       dispat_ready;
   logic [OPW-1:0]             dispat_op;
   logic [XLEN-1:0]            dispat_pc;
   logic [XLEN-1:0]            dispat_imm;
   logic [PW-1:0]              dispat_rd0, dispat_rs1, dispat_rs2;
   logic                       dispat_is_rvc;
   logic [32*RNDEPTH-1:0]      wb_buffer_qout;
   logic [XLEN*32*RNDEPTH-1:0] regFileX_read;
   logic                       execute_valid;
   logic                       execute_ready;
   logic [OPW-1:0]             execute_op;
   logic [XLEN-1:0]            execute_pc, execute_imm, execute_src1, execute_src2;
   logic [PW-1:0]              execute_rd0;
   logic                       execute_is_rvc;

   int n_pass = 0;
   int n_total = 0;

   bru_issue_queue #(.DP(DP), .RNDEPTH(RNDEPTH), .RNBIT(RNBIT), .XLEN(XLEN), .OPW(OPW)) dut (
      .CLK(CLK), .RSTn(RSTn), .flush(flush),
      .dispat_valid(dispat_valid), .dispat_ready(dispat_ready), .dispat_op(dispat_op),
      .dispat_pc(dispat_pc), .dispat_imm(dispat_imm), .dispat_rd0(dispat_rd0),
      .dispat_rs1(dispat_rs1), .dispat_rs2(dispat_rs2), .dispat_is_rvc(dispat_is_rvc),
      .wb_buffer_qout(wb_buffer_qout), .regFileX_read(regFileX_read),
      .execute_valid(execute_valid), .execute_ready(execute_ready), .execute_op(execute_op),
      .execute_pc(execute_pc), .execute_imm(execute_imm), .execute_rd0(execute_rd0),
      .execute_src1(execute_src1), .execute_src2(execute_src2), .execute_is_rvc(execute_is_rvc)
   );

   always #5 CLK = ~CLK;

   function automatic logic [63:0] regv(input int p);
      return 64'hA5A5_0000_0000_0000 | 64'(p * 16 + 3);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [7:0] op, input logic [63:0] pc, input logic [63:0] imm,
                        input logic [6:0] rd, input logic [6:0] rs1, input logic [6:0] rs2);
      dispat_valid = 1'b1;
      dispat_op    = op;
      dispat_pc    = pc;
      dispat_imm   = imm;
      dispat_rd0   = rd;
      dispat_rs1   = rs1;
      dispat_rs2   = rs2;
   endtask

   initial begin
      RSTn = 1'b0; flush = 1'b0; dispat_valid = 1'b0; dispat_op = '0; dispat_pc = '0;
      dispat_imm = '0; dispat_rd0 = '0; dispat_rs1 = '0; dispat_rs2 = '0; dispat_is_rvc = 1'b0;
      wb_buffer_qout = '0; execute_ready = 1'b1;
      for (int p = 0; p < 32*RNDEPTH; p++) regFileX_read[p*XLEN +: XLEN] = regv(p);
      #3;
      chk("rst_exec_valid", 64'(execute_valid), 64'd0);
      chk("rst_exec_pc", execute_pc, 64'd0);
      chk("rst_dispat_ready", 64'(dispat_ready), 64'd1);
      chk("rst_qvalid", 64'(dut.q_valid), 64'd0);
      #9 RSTn = 1'b1;
      tick();

      // jal issues one cycle after entering the queue
      drive(8'h01, 64'h1000, 64'h20, 7'd5, 7'd0, 7'd0);
      tick();
      dispat_valid = 1'b0;
      chk("jal_not_yet", 64'(execute_valid), 64'd0);
      tick();
      chk("jal_valid", 64'(execute_valid), 64'd1);
      chk("jal_op", 64'(execute_op), 64'h01);
      chk("jal_pc", execute_pc, 64'h1000);
      chk("jal_imm", execute_imm, 64'h20);
      chk("jal_rd0", 64'(execute_rd0), 64'd5);
      chk("jal_q_empty", 64'(dut.q_valid), 64'd0);
      tick();
      chk("idle_valid", 64'(execute_valid), 64'd0);
      chk("idle_pc_hold", execute_pc, 64'h1000);

      // younger ready jal overtakes a jalr waiting on p9
      drive(8'h02, 64'h2000, 64'h8, 7'd6, 7'd9, 7'd0);
      tick();
      drive(8'h01, 64'h3000, 64'h4, 7'd7, 7'd0, 7'd0);
      tick();
      dispat_valid = 1'b0;
      tick();
      chk("ooo_jal_pc", execute_pc, 64'h3000);
      chk("ooo_q", 64'(dut.q_valid), 64'b0001);
      wb_buffer_qout[9] = 1'b1;
      tick();
      chk("jalr_valid", 64'(execute_valid), 64'd1);
      chk("jalr_pc", execute_pc, 64'h2000);
      chk("jalr_src1", execute_src1, regv(9));
      chk("jalr_q_empty", 64'(dut.q_valid), 64'd0);
      wb_buffer_qout = '0;
      tick();

      // fill with unready branches, then pop middle entry while pushing
      for (int i = 0; i < DP; i++) begin
         drive(8'h04, 64'h4000 + 64'(4*i), 64'h10, 7'd40 + 7'(i), 7'd16 + 7'(2*i), 7'd17 + 7'(2*i));
         tick();
      end
      dispat_valid = 1'b0;
      #1;
      chk("full_ready_low", 64'(dispat_ready), 64'd0);
      chk("full_q", 64'(dut.q_valid), 64'b1111);
      drive(8'h08, 64'h5000, 64'h30, 7'd50, 7'd24, 7'd25);
      wb_buffer_qout[20] = 1'b1;
      wb_buffer_qout[21] = 1'b1;
      #1;
      chk("full_pop_ready", 64'(dispat_ready), 64'd1);
      tick();
      dispat_valid = 1'b0;
      wb_buffer_qout = '0;
      chk("mid_pop_pc", execute_pc, 64'h4008);
      chk("mid_pop_src1", execute_src1, regv(20));
      chk("mid_pop_src2", execute_src2, regv(21));
      chk("mid_pop_q", 64'(dut.q_valid), 64'b1111);
      chk("shift_e2", dut.q_ent[2].pc, 64'h400C);
      chk("new_e3", dut.q_ent[3].pc, 64'h5000);

      // backpressure holds the output even with a ready entry
      execute_ready = 1'b0;
      wb_buffer_qout[16] = 1'b1;
      wb_buffer_qout[17] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("stall_valid", 64'(execute_valid), 64'd1);
         chk("stall_pc", execute_pc, 64'h4008);
         chk("stall_q", 64'(dut.q_valid), 64'b1111);
      end
      chk("stall_dispat_ready", 64'(dispat_ready), 64'd0);
      execute_ready = 1'b1;
      tick();
      chk("release_pc", execute_pc, 64'h4000);
      chk("release_src1", execute_src1, regv(16));
      chk("release_q", 64'(dut.q_valid), 64'b0111);
      chk("release_e0", dut.q_ent[0].pc, 64'h4004);
      wb_buffer_qout = '0;

      // flush drops queue, output and the concurrent push
      drive(8'h01, 64'h6000, 64'h0, 7'd8, 7'd0, 7'd0);
      flush = 1'b1;
      #1;
      chk("flush_dispat_ready", 64'(dispat_ready), 64'd0);
      tick();
      flush = 1'b0;
      dispat_valid = 1'b0;
      chk("flush_valid", 64'(execute_valid), 64'd0);
      chk("flush_q", 64'(dut.q_valid), 64'd0);
      tick();
      chk("flush_no_push", 64'(execute_valid), 64'd0);

      // beq with rs1 in x0 (copy 2) is ready and reads zero
      wb_buffer_qout[13] = 1'b1;
      drive(8'h04, 64'h7000, 64'h40, 7'd11, 7'd2, 7'd13);
      tick();
      dispat_valid = 1'b0;
      tick();
      chk("x0_valid", 64'(execute_valid), 64'd1);
      chk("x0_pc", execute_pc, 64'h7000);
      chk("x0_src1", execute_src1, 64'd0);
      chk("x0_src2", execute_src2, regv(13));

      // asynchronous reset mid-operation
      execute_ready = 1'b0;
      drive(8'h02, 64'h8000, 64'h0, 7'd12, 7'd30, 7'd0);
      tick();
      dispat_valid = 1'b0;
      chk("pre_rst_q", 64'(dut.q_valid), 64'b0001);
      #2 RSTn = 1'b0;
      #1;
      chk("async_rst_valid", 64'(execute_valid), 64'd0);
      chk("async_rst_pc", execute_pc, 64'd0);
      chk("async_rst_q", 64'(dut.q_valid), 64'd0);
      RSTn = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
